// File: rtl/rom_arbiter.sv
// ============================================================================
// Module : rom_arbiter
// Two-master arbiter and access sequencer for the 32Kx8 program PROM.
// Drives the active-low ROM chip-select / output-enable for a programmable
// window, then returns the sampled data to the granted master with an ack.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_arbiter #(
   parameter int ADDR_W   = 15,
   parameter int DATA_W   = 8,
   parameter int WAIT_CYC = 2,
   parameter int ARB_MODE = 0
) (
   input  logic              clk,
   input  logic              sys_rst_n,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_cs,
   output logic              rom_oe,
   input  logic [DATA_W-1:0] rom_data,
   output logic              busy,
   output logic              grant
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   // Counter preload: WAIT_CYC edges in ACCESS means counting WAIT_CYC-1 down to 0
   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

   logic [1:0] state;
   logic [1:0] next_state;
   logic [3:0] cnt;
   logic       last_grant;
   logic       any_req;
   logic       win_m1;
   logic       cnt_zero;

   // Arbitration: pick the winner among the current requests
   always_comb begin
      any_req  = m0_req | m1_req;
      cnt_zero = (cnt == 4'd0);
      if (ARB_MODE == 1) begin
         // m0 always wins whenever it is requesting
         win_m1 = ~m0_req;
      end else begin
         // On a tie, the master that did not own the last access wins
         win_m1 = m1_req & (~m0_req | ~last_grant);
      end
   end

   // State register
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (any_req)  next_state = S_ACCESS;
         S_ACCESS: if (cnt_zero) next_state = S_DONE;
         S_DONE:                 next_state = S_IDLE;
         default:                next_state = S_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      busy = (state != S_IDLE);
   end

   // Registered ROM control, wait counter, grant tracking and read-data return
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rom_addr   <= '0;
         rom_cs     <= 1'b1;
         rom_oe     <= 1'b1;
         cnt        <= 4'd0;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         m0_ack     <= 1'b0;
         m1_ack     <= 1'b0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  // Address is captured here; later address changes are ignored
                  rom_addr   <= win_m1 ? m1_addr : m0_addr;
                  rom_cs     <= 1'b0;
                  rom_oe     <= 1'b0;
                  grant      <= win_m1;
                  last_grant <= win_m1;
                  cnt        <= CNT_INIT;
               end
            end
            S_ACCESS: begin
               if (!cnt_zero) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  // Final access edge: sample ROM, release the bus, ack the owner
                  if (grant) begin
                     m1_rdata <= rom_data;
                     m1_ack   <= 1'b1;
                  end else begin
                     m0_rdata <= rom_data;
                     m0_ack   <= 1'b1;
                  end
                  rom_cs <= 1'b1;
                  rom_oe <= 1'b1;
               end
            end
            S_DONE: begin
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
            end
            default: begin
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
// ============================================================================
// Module : tb_rom_arbiter
// Self-checking bench for rom_arbiter: a round-robin instance (index 0) and a
// fixed-priority instance (index 1) share clock, reset and a ROM image.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_arbiter;

   localparam int W = 2;

   logic        clk;
   logic        rst_n;
   logic        m0_req   [2];
   logic [14:0] m0_addr  [2];
   logic        m0_ack   [2];
   logic [7:0]  m0_rdata [2];
   logic        m1_req   [2];
   logic [14:0] m1_addr  [2];
   logic        m1_ack   [2];
   logic [7:0]  m1_rdata [2];
   logic [14:0] rom_addr [2];
   logic        rom_cs   [2];
   logic        rom_oe   [2];
   logic [7:0]  rom_data [2];
   logic        busy     [2];
   logic        grant    [2];

   logic [7:0]  mem [0:32767];

   int n_cmp = 0;
   int n_err = 0;

   rom_arbiter #(.ADDR_W(15), .DATA_W(8), .WAIT_CYC(W), .ARB_MODE(0)) dut_rr (
      .clk(clk), .sys_rst_n(rst_n),
      .m0_req(m0_req[0]), .m0_addr(m0_addr[0]), .m0_ack(m0_ack[0]), .m0_rdata(m0_rdata[0]),
      .m1_req(m1_req[0]), .m1_addr(m1_addr[0]), .m1_ack(m1_ack[0]), .m1_rdata(m1_rdata[0]),
      .rom_addr(rom_addr[0]), .rom_cs(rom_cs[0]), .rom_oe(rom_oe[0]), .rom_data(rom_data[0]),
      .busy(busy[0]), .grant(grant[0]));

   rom_arbiter #(.ADDR_W(15), .DATA_W(8), .WAIT_CYC(W), .ARB_MODE(1)) dut_fp (
      .clk(clk), .sys_rst_n(rst_n),
      .m0_req(m0_req[1]), .m0_addr(m0_addr[1]), .m0_ack(m0_ack[1]), .m0_rdata(m0_rdata[1]),
      .m1_req(m1_req[1]), .m1_addr(m1_addr[1]), .m1_ack(m1_ack[1]), .m1_rdata(m1_rdata[1]),
      .rom_addr(rom_addr[1]), .rom_cs(rom_cs[1]), .rom_oe(rom_oe[1]), .rom_data(rom_data[1]),
      .busy(busy[1]), .grant(grant[1]));

   // ROM model: asynchronous read of the image
   assign rom_data[0] = mem[rom_addr[0]];
   assign rom_data[1] = mem[rom_addr[1]];

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // Transaction-level reference: an access lasts W cycles with the ROM
   // selected, then one ack cycle, then the arbiter is free again.
   // ---------------------------------------------------------------------
   bit          md_act  [2];
   int          md_e    [2];
   bit          md_own  [2];
   bit          md_last [2];
   logic [14:0] md_addr [2];
   logic [7:0]  md_rd0  [2];
   logic [7:0]  md_rd1  [2];

   function automatic bit pick_m1(int i);
      if (i == 1) return !m0_req[i];
      if (m0_req[i] && m1_req[i]) return (md_last[i] == 1'b0);
      return m1_req[i];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            md_act[i]  <= 1'b0;
            md_e[i]    <= 0;
            md_own[i]  <= 1'b0;
            md_last[i] <= 1'b1;
            md_addr[i] <= '0;
            md_rd0[i]  <= '0;
            md_rd1[i]  <= '0;
         end else if (md_act[i]) begin
            md_e[i] <= md_e[i] + 1;
            if (md_e[i] + 1 == W) begin
               if (md_own[i]) md_rd1[i] <= mem[md_addr[i]];
               else           md_rd0[i] <= mem[md_addr[i]];
            end
            if (md_e[i] + 1 == W + 1) md_act[i] <= 1'b0;
         end else if (m0_req[i] || m1_req[i]) begin
            md_act[i]  <= 1'b1;
            md_e[i]    <= 0;
            md_own[i]  <= pick_m1(i);
            md_last[i] <= pick_m1(i);
            md_addr[i] <= pick_m1(i) ? m1_addr[i] : m0_addr[i];
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle_all();
      for (int i = 0; i < 2; i++) begin
         m0_req[i] = 1'b0;
         m1_req[i] = 1'b0;
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m0_req[i] = 1'b1; m0_addr[i] = 15'h0055;
         m1_req[i] = 1'b1; m1_addr[i] = 15'h0066;
      end
      repeat (3) tick();
      for (int i = 0; i < 2; i++) begin
         n_cmp++; if (rom_cs[i] !== 1'b1 || rom_oe[i] !== 1'b1) begin n_err++; $display("FAIL reset_cs_oe[%0d]: got %b%b expected 11", i, rom_cs[i], rom_oe[i]); end
         n_cmp++; if (m0_ack[i] !== 1'b0 || m1_ack[i] !== 1'b0) begin n_err++; $display("FAIL reset_ack[%0d]: got %b%b expected 00", i, m0_ack[i], m1_ack[i]); end
         n_cmp++; if (m0_rdata[i] !== 8'h00 || m1_rdata[i] !== 8'h00) begin n_err++; $display("FAIL reset_rdata[%0d]: got %h %h expected 00 00", i, m0_rdata[i], m1_rdata[i]); end
         n_cmp++; if (rom_addr[i] !== 15'h0) begin n_err++; $display("FAIL reset_addr[%0d]: got %h expected 0000", i, rom_addr[i]); end
         n_cmp++; if (busy[i] !== 1'b0 || grant[i] !== 1'b0) begin n_err++; $display("FAIL reset_busy_grant[%0d]: got %b%b expected 00", i, busy[i], grant[i]); end
      end
      rst_n = 1'b1;
      tick();
      n_cmp++; if (grant[0] !== 1'b0 || rom_addr[0] !== 15'h0055 || rom_cs[0] !== 1'b0) begin n_err++; $display("FAIL reset_first_grant: got g=%b a=%h cs=%b expected g=0 a=0055 cs=0", grant[0], rom_addr[0], rom_cs[0]); end
      idle_all();
      repeat (W + 3) tick();
   endtask

   // ---------------------------------------------------------------------
   task automatic test_single_read();
      m0_addr[0] = 15'h0010; m0_req[0] = 1'b1;
      tick();
      n_cmp++; if (rom_addr[0] !== 15'h0010 || rom_cs[0] !== 1'b0 || rom_oe[0] !== 1'b0) begin n_err++; $display("FAIL single_c1: got a=%h cs=%b oe=%b expected a=0010 cs=0 oe=0", rom_addr[0], rom_cs[0], rom_oe[0]); end
      tick();
      n_cmp++; if (rom_cs[0] !== 1'b0 || m0_ack[0] !== 1'b0) begin n_err++; $display("FAIL single_c2: got cs=%b ack=%b expected cs=0 ack=0", rom_cs[0], m0_ack[0]); end
      tick();
      n_cmp++; if (rom_cs[0] !== 1'b1 || m0_ack[0] !== 1'b1 || m1_ack[0] !== 1'b0) begin n_err++; $display("FAIL single_c3: got cs=%b ack0=%b ack1=%b expected 1 1 0", rom_cs[0], m0_ack[0], m1_ack[0]); end
      n_cmp++; if (m0_rdata[0] !== 8'hA5) begin n_err++; $display("FAIL single_rdata: got %h expected a5", m0_rdata[0]); end
      m0_req[0] = 1'b0;
      tick();
      n_cmp++; if (m0_ack[0] !== 1'b0 || busy[0] !== 1'b0) begin n_err++; $display("FAIL single_c4: got ack=%b busy=%b expected 0 0", m0_ack[0], busy[0]); end
      repeat (2) tick();
   endtask

   // ---------------------------------------------------------------------
   task automatic test_round_robin();
      int acks = 0;
      int last_cyc = 0;
      bit exp_own = 1'b1;  // m0 owned the previous access, so m1 wins the first tie
      m0_addr[0] = 15'h0001; m1_addr[0] = 15'h7FFF;
      m0_req[0] = 1'b1; m1_req[0] = 1'b1;
      for (int cyc = 1; cyc <= 40 && acks < 4; cyc++) begin
         tick();
         if (m0_ack[0] || m1_ack[0]) begin
            n_cmp++; if (m1_ack[0] !== exp_own || (m0_ack[0] && m1_ack[0])) begin n_err++; $display("FAIL rr_order: got ack0=%b ack1=%b expected owner %0d", m0_ack[0], m1_ack[0], exp_own); end
            if (acks > 0) begin
               n_cmp++; if (cyc - last_cyc != W + 2) begin n_err++; $display("FAIL rr_spacing: got %0d expected %0d", cyc - last_cyc, W + 2); end
            end
            n_cmp++; if ((exp_own && m1_rdata[0] !== 8'hEE) || (!exp_own && m0_rdata[0] !== 8'h11)) begin n_err++; $display("FAIL rr_rdata: got %h %h expected 11/ee", m0_rdata[0], m1_rdata[0]); end
            if (acks >= 2) begin
               n_cmp++; if (m0_rdata[0] !== 8'h11 || m1_rdata[0] !== 8'hEE) begin n_err++; $display("FAIL rr_cross: got %h %h expected 11 ee", m0_rdata[0], m1_rdata[0]); end
            end
            last_cyc = cyc;
            exp_own = ~exp_own;
            acks++;
         end
      end
      n_cmp++; if (acks != 4) begin n_err++; $display("FAIL rr_count: got %0d expected 4", acks); end
      idle_all();
      repeat (W + 4) tick();
   endtask

   // ---------------------------------------------------------------------
   task automatic test_fixed_priority();
      int a0 = 0;
      int a1 = 0;
      int k;
      m0_addr[1] = 15'h0001; m1_addr[1] = 15'h7FFF;
      m0_req[1] = 1'b1; m1_req[1] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (m0_ack[1]) a0++;
         if (m1_ack[1]) a1++;
      end
      n_cmp++; if (a0 != 5 || a1 != 0) begin n_err++; $display("FAIL fp_counts: got m0=%0d m1=%0d expected 5 0", a0, a1); end
      for (k = 0; k < 10 && !m0_ack[1]; k++) tick();
      n_cmp++; if (m0_ack[1] !== 1'b1) begin n_err++; $display("FAIL fp_wait_m0: got %b expected 1", m0_ack[1]); end
      m0_req[1] = 1'b0;
      repeat (2) tick();
      n_cmp++; if (grant[1] !== 1'b1 || rom_cs[1] !== 1'b0 || rom_addr[1] !== 15'h7FFF) begin n_err++; $display("FAIL fp_m1_grant: got g=%b cs=%b a=%h expected 1 0 7fff", grant[1], rom_cs[1], rom_addr[1]); end
      for (k = 0; k < 10 && !m1_ack[1]; k++) tick();
      n_cmp++; if (m1_ack[1] !== 1'b1 || m1_rdata[1] !== 8'hEE) begin n_err++; $display("FAIL fp_m1_data: got ack=%b d=%h expected 1 ee", m1_ack[1], m1_rdata[1]); end
      idle_all();
      repeat (3) tick();
   endtask

   // ---------------------------------------------------------------------
   task automatic test_async_reset();
      int k;
      m1_addr[0] = 15'h1234; m1_req[0] = 1'b1;
      tick();
      n_cmp++; if (grant[0] !== 1'b1 || rom_cs[0] !== 1'b0) begin n_err++; $display("FAIL ar_grant: got g=%b cs=%b expected 1 0", grant[0], rom_cs[0]); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (rom_cs[0] !== 1'b1 || rom_oe[0] !== 1'b1) begin n_err++; $display("FAIL ar_immediate: got cs=%b oe=%b expected 1 1", rom_cs[0], rom_oe[0]); end
      n_cmp++; if (m1_ack[0] !== 1'b0 || m1_rdata[0] !== 8'h00) begin n_err++; $display("FAIL ar_no_ack: got ack=%b d=%h expected 0 00", m1_ack[0], m1_rdata[0]); end
      repeat (2) tick();
      n_cmp++; if (m1_ack[0] !== 1'b0 || rom_cs[0] !== 1'b1) begin n_err++; $display("FAIL ar_hold: got ack=%b cs=%b expected 0 1", m1_ack[0], rom_cs[0]); end
      rst_n = 1'b1;
      for (k = 1; k <= 12; k++) begin
         tick();
         if (m1_ack[0]) break;
      end
      n_cmp++; if (m1_ack[0] !== 1'b1 || k != W + 1) begin n_err++; $display("FAIL ar_reserve: got ack=%b latency=%0d expected 1 %0d", m1_ack[0], k, W + 1); end
      n_cmp++; if (m1_rdata[0] !== 8'h5A) begin n_err++; $display("FAIL ar_rdata: got %h expected 5a", m1_rdata[0]); end
      idle_all();
      repeat (3) tick();
   endtask

   // ---------------------------------------------------------------------
   task automatic test_addr_change();
      int k;
      m0_addr[0] = 15'h0100; m0_req[0] = 1'b1;
      tick();
      n_cmp++; if (rom_addr[0] !== 15'h0100) begin n_err++; $display("FAIL ac_grant_addr: got %h expected 0100", rom_addr[0]); end
      m0_addr[0] = 15'h0200;
      tick();
      n_cmp++; if (rom_addr[0] !== 15'h0100 || rom_cs[0] !== 1'b0) begin n_err++; $display("FAIL ac_stable: got a=%h cs=%b expected 0100 0", rom_addr[0], rom_cs[0]); end
      for (k = 0; k < 10 && !m0_ack[0]; k++) tick();
      n_cmp++; if (m0_ack[0] !== 1'b1 || m0_rdata[0] !== 8'h3C) begin n_err++; $display("FAIL ac_rdata: got ack=%b d=%h expected 1 3c", m0_ack[0], m0_rdata[0]); end
      idle_all();
      repeat (3) tick();
   endtask

   // ---------------------------------------------------------------------
   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            n_cmp++; if (rom_cs[i] !== !(md_act[i] && md_e[i] < W)) begin n_err++; $display("FAIL rnd_cs[%0d] c%0d: got %b expected %b", i, c, rom_cs[i], !(md_act[i] && md_e[i] < W)); end
            n_cmp++; if (rom_oe[i] !== rom_cs[i]) begin n_err++; $display("FAIL rnd_oe[%0d] c%0d: got %b expected %b", i, c, rom_oe[i], rom_cs[i]); end
            n_cmp++; if (rom_addr[i] !== md_addr[i]) begin n_err++; $display("FAIL rnd_addr[%0d] c%0d: got %h expected %h", i, c, rom_addr[i], md_addr[i]); end
            n_cmp++; if (m0_ack[i] !== (md_act[i] && md_e[i] == W && !md_own[i])) begin n_err++; $display("FAIL rnd_ack0[%0d] c%0d: got %b", i, c, m0_ack[i]); end
            n_cmp++; if (m1_ack[i] !== (md_act[i] && md_e[i] == W && md_own[i])) begin n_err++; $display("FAIL rnd_ack1[%0d] c%0d: got %b", i, c, m1_ack[i]); end
            n_cmp++; if (m0_rdata[i] !== md_rd0[i]) begin n_err++; $display("FAIL rnd_rd0[%0d] c%0d: got %h expected %h", i, c, m0_rdata[i], md_rd0[i]); end
            n_cmp++; if (m1_rdata[i] !== md_rd1[i]) begin n_err++; $display("FAIL rnd_rd1[%0d] c%0d: got %h expected %h", i, c, m1_rdata[i], md_rd1[i]); end
            n_cmp++; if (busy[i] !== md_act[i]) begin n_err++; $display("FAIL rnd_busy[%0d] c%0d: got %b expected %b", i, c, busy[i], md_act[i]); end
            n_cmp++; if (grant[i] !== md_own[i]) begin n_err++; $display("FAIL rnd_grant[%0d] c%0d: got %b expected %b", i, c, grant[i], md_own[i]); end
            // Requesters obey the protocol: hold req until ack, then maybe drop
            if (!m0_req[i]) begin
               if ($urandom_range(0, 2) == 0) begin m0_req[i] = 1'b1; m0_addr[i] = 15'($urandom); end
            end else if (m0_ack[i]) begin
               if ($urandom_range(0, 1) == 0) m0_req[i] = 1'b0; else m0_addr[i] = 15'($urandom);
            end
            if (!m1_req[i]) begin
               if ($urandom_range(0, 2) == 0) begin m1_req[i] = 1'b1; m1_addr[i] = 15'($urandom); end
            end else if (m1_ack[i]) begin
               if ($urandom_range(0, 1) == 0) m1_req[i] = 1'b0; else m1_addr[i] = 15'($urandom);
            end
         end
      end
      idle_all();
      repeat (W + 3) tick();
   endtask

   // ---------------------------------------------------------------------
   initial begin
      clk   = 1'b0;
      rst_n = 1'b0;
      for (int a = 0; a < 32768; a++) mem[a] = 8'((a * 37) ^ (a >> 7));
      mem[15'h0010] = 8'hA5;
      mem[15'h0001] = 8'h11;
      mem[15'h7FFF] = 8'hEE;
      mem[15'h1234] = 8'h5A;
      mem[15'h0100] = 8'h3C;
      mem[15'h0200] = 8'hC3;
      for (int i = 0; i < 2; i++) begin
         m0_req[i] = 1'b0; m0_addr[i] = '0;
         m1_req[i] = 1'b0; m1_addr[i] = '0;
      end
      tick();
      test_reset();
      test_single_read();
      test_round_robin();
      test_fixed_priority();
      test_async_reset();
      test_addr_change();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
